// File: rtl/bp_perf_if.sv
// Bundle of the performance monitor's control strobes, event inputs and read port.
// The core/bench side uses the master modport; bp_perf_monitor uses the slave modport.
interface bp_perf_if #(
  parameter int CNT_W = 32,
  parameter int N_EXT = 2,
  parameter int SEL_W = 4
);
  logic             start;
  logic             clear;
  logic             finish;
  logic             branch;
  logic             correct;
  logic             stall;
  logic [N_EXT-1:0] ext_ev;
  logic             rd_req;
  logic [SEL_W-1:0] rd_sel;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             running;
  logic             done;
  logic             ovf;

  modport master (
    output start, clear, finish, branch, correct, stall, ext_ev, rd_req, rd_sel,
    input  rd_valid, rd_data, running, done, ovf
  );

  modport slave (
    input  start, clear, finish, branch, correct, stall, ext_ev, rd_req, rd_sel,
    output rd_valid, rd_data, running, done, ovf
  );
endinterface

// File: rtl/bp_perf_monitor.sv
// Saturating cycle/branch/miss/event counters with an IDLE->RUN->DONE lifecycle and a
// one-cycle-latency read port. Define BP_PERF_WINDOW_EN to add the per-epoch miss counter.
module bp_perf_monitor #(
  parameter int CNT_W    = 32,
  parameter int N_EXT    = 2,
  parameter int SEL_W    = 4,
  parameter int WIN_LOG2 = 6
) (
  input logic     clk,
  input logic     rst_n,
  bp_perf_if.slave bus
);

  localparam logic [1:0]       ST_IDLE = 2'd0;
  localparam logic [1:0]       ST_RUN  = 2'd1;
  localparam logic [1:0]       ST_DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               IDX_STATUS = 3 + N_EXT;
  localparam int               IDX_WIN    = 4 + N_EXT;

  if (N_EXT < 1 || N_EXT > 8) begin : g_bad_n_ext
    $error("bp_perf_monitor: N_EXT must be in 1..8");
  end
  if ((1 << SEL_W) < N_EXT + 4) begin : g_bad_sel_w
    $error("bp_perf_monitor: SEL_W too narrow for the counter map");
  end
  if (WIN_LOG2 < 1) begin : g_bad_win
    $error("bp_perf_monitor: WIN_LOG2 must be at least 1");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_br;
  logic [CNT_W-1:0] r_miss;
  logic [CNT_W-1:0] r_ext [N_EXT];
  logic             r_ovf;
  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;

  logic             w_run;
  logic             w_done;
  logic             w_inc_br;
  logic             w_inc_miss;
  logic [N_EXT-1:0] w_inc_ext;
  logic [N_EXT-1:0] w_ext_sat;
  logic             w_sat_hit;
  logic [2:0]       w_status;
  logic [CNT_W-1:0] w_rd_mux;

  assign w_run      = (r_state == ST_RUN);
  assign w_done     = (r_state == ST_DONE);
  assign w_inc_br   = w_run & bus.branch & ~bus.stall;
  assign w_inc_miss = w_inc_br & ~bus.correct;
  assign w_status   = {r_ovf, w_done, w_run};

  always_comb begin
    for (int i = 0; i < N_EXT; i++) begin
      w_inc_ext[i] = w_run & bus.ext_ev[i] & ~bus.stall;
      w_ext_sat[i] = (r_ext[i] == CNT_MAX);
    end
  end

  // An increment that lands on a full counter is dropped and raises the sticky flag.
  assign w_sat_hit = (w_run      & (r_cyc  == CNT_MAX)) |
                     (w_inc_br   & (r_br   == CNT_MAX)) |
                     (w_inc_miss & (r_miss == CNT_MAX)) |
                     (|(w_inc_ext & w_ext_sat));

  // ---------------------------------------------------------------- lifecycle FSM
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start)  w_state_nxt = ST_RUN;
        ST_RUN:  if (bus.finish) w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc  <= '0;
      r_br   <= '0;
      r_miss <= '0;
      r_ovf  <= 1'b0;
      // NOTE: the ext array is a handful of flops, not a RAM, so it gets an explicit reset.
      for (int i = 0; i < N_EXT; i++) r_ext[i] <= '0;
    end else if (bus.clear) begin
      r_cyc  <= '0;
      r_br   <= '0;
      r_miss <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < N_EXT; i++) r_ext[i] <= '0;
    end else begin
      if (w_run && (r_cyc != CNT_MAX))       r_cyc  <= r_cyc + CNT_ONE;
      if (w_inc_br && (r_br != CNT_MAX))     r_br   <= r_br + CNT_ONE;
      if (w_inc_miss && (r_miss != CNT_MAX)) r_miss <= r_miss + CNT_ONE;
      for (int i = 0; i < N_EXT; i++) begin
        if (w_inc_ext[i] && !w_ext_sat[i]) r_ext[i] <= r_ext[i] + CNT_ONE;
      end
      if (w_sat_hit) r_ovf <= 1'b1;
    end
  end

`ifdef BP_PERF_WINDOW_EN
  // ---------------------------------------------------------------- epoch window
  logic [WIN_LOG2-1:0] r_ep_br;
  logic [WIN_LOG2:0]   r_ep_miss;
  logic [WIN_LOG2:0]   r_win_miss;
  logic [WIN_LOG2:0]   w_ep_miss_nxt;
  logic                w_ep_wrap;

  assign w_ep_miss_nxt = r_ep_miss + (WIN_LOG2 + 1)'(w_inc_miss);
  assign w_ep_wrap     = w_inc_br & (r_ep_br == '1);

  // The wrapping branch's own miss is part of the epoch being latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ep_br    <= '0;
      r_ep_miss  <= '0;
      r_win_miss <= '0;
    end else if (bus.clear) begin
      r_ep_br    <= '0;
      r_ep_miss  <= '0;
      r_win_miss <= '0;
    end else if (w_inc_br) begin
      r_ep_br <= r_ep_br + WIN_LOG2'(1);
      if (w_ep_wrap) begin
        r_win_miss <= w_ep_miss_nxt;
        r_ep_miss  <= '0;
      end else begin
        r_ep_miss  <= w_ep_miss_nxt;
      end
    end
  end
`endif

  // ---------------------------------------------------------------- read port
  always_comb begin
    w_rd_mux = '0;
    if (int'(bus.rd_sel) == 0) w_rd_mux = r_cyc;
    if (int'(bus.rd_sel) == 1) w_rd_mux = r_br;
    if (int'(bus.rd_sel) == 2) w_rd_mux = r_miss;
    for (int i = 0; i < N_EXT; i++) begin
      if (int'(bus.rd_sel) == 3 + i) w_rd_mux = r_ext[i];
    end
    if (int'(bus.rd_sel) == IDX_STATUS) w_rd_mux = CNT_W'(w_status);
`ifdef BP_PERF_WINDOW_EN
    if (int'(bus.rd_sel) == IDX_WIN) w_rd_mux = CNT_W'(r_win_miss);
`endif
  end

  // Read data is captured from pre-increment counters and is untouched by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) r_rd_data <= w_rd_mux;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.running  = w_run;
  assign bus.done     = w_done;
  assign bus.ovf      = r_ovf;

endmodule
